wb_load_unit: RTL and testbench

WB_LOAD_UNIT -- requirements
Module: wb_load_unit

---
 rtl/wb_load_unit.sv | 171 +++++++++++++++++
 tb/tb_wb_load_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_load_unit.sv
// Load writeback unit. Keeps an in-order FIFO of outstanding load descriptors,
// formats returning load data, and shares a registered register-file write port.
module wb_load_unit #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 4,
    localparam int OW    = $clog2(XLEN/8),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rd,
    input  logic [2:0]      issue_funct3,
    input  logic [OW-1:0]   issue_offset,
    input  logic            mem_resp,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            load_regfile,
    output logic [4:0]      rd_reg,
    output logic [XLEN-1:0] regfile_wdata,
    output logic [PW:0]     pending,
    output logic            resp_err
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [4:0]    rd;
        logic [2:0]    funct3;
        logic [OW-1:0] offset;
    } desc_t;

    function automatic logic is_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            F3_LD, F3_LWU:                       ok = (XLEN == 64);
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] format_load(
        input logic [2:0]      f3,
        input logic [OW-1:0]   off,
        input logic [XLEN-1:0] word
    );
        logic [OW-1:0]   lane;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        // Lane start is the offset aligned down to the access size.
        case (f3)
            F3_LB, F3_LBU:        lane = off;
            F3_LH, F3_LHU:        lane = off & ~OW'(1);
            F3_LD:                lane = '0;
            default:              lane = off & ~OW'(3);
        endcase
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_LB:   res = XLEN'($signed(sh[7:0]));
            F3_LBU:  res = XLEN'(sh[7:0]);
            F3_LH:   res = XLEN'($signed(sh[15:0]));
            F3_LHU:  res = XLEN'(sh[15:0]);
            F3_LWU:  res = XLEN'(sh[31:0]);
            F3_LD:   res = sh;
            default: res = XLEN'($signed(sh[31:0]));
        endcase
        return res;
    endfunction

    // NOTE: descriptor storage has no reset; only pointers and count define validity.
    desc_t fifo_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic  push, pop, drop;
    desc_t head, issue_desc;

    assign issue_ready = (count_q != (PW+1)'(DEPTH));
    assign alu_ready   = !mem_resp;
    assign push        = issue_valid && issue_ready;
    assign pop         = mem_resp && (count_q != '0);
    assign drop        = mem_resp && (count_q == '0);
    assign head        = fifo_q[rd_ptr_q];

    // Unsupported load types are queued as lw so the response still retires.
    always_comb begin
        issue_desc.rd     = issue_rd;
        issue_desc.funct3 = is_legal(issue_funct3) ? issue_funct3 : F3_LW;
        issue_desc.offset = issue_offset;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q | drop | (push && !is_legal(issue_funct3));

        we_d    = 1'b0;
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (pop) begin
            if (head.rd != '0) begin
                we_d    = 1'b1;
                rd_d    = head.rd;
                wdata_d = format_load(head.funct3, head.offset, mem_rdata);
            end
        end else if (alu_valid && alu_ready && (alu_rd != '0)) begin
            we_d    = 1'b1;
            rd_d    = alu_rd;
            wdata_d = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= issue_desc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
        end
    end

    assign load_regfile  = we_q;
    assign rd_reg        = rd_q;
    assign regfile_wdata = wdata_q;
    assign pending       = count_q;
    assign resp_err      = err_q;

endmodule

// File: tb/tb_wb_load_unit.sv
// Self-checking bench for wb_load_unit: directed vectors, a queue-based
// reference model compared every cycle, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_wb_load_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int OW    = 2;
    localparam int PW    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [4:0]      issue_rd = '0;
    logic [2:0]      issue_funct3 = '0;
    logic [OW-1:0]   issue_offset = '0;
    logic            mem_resp = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            load_regfile;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] regfile_wdata;
    logic [PW:0]     pending;
    logic            resp_err;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    wb_load_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rd      (issue_rd),
        .issue_funct3  (issue_funct3),
        .issue_offset  (issue_offset),
        .mem_resp      (mem_resp),
        .mem_rdata     (mem_rdata),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .load_regfile  (load_regfile),
        .rd_reg        (rd_reg),
        .regfile_wdata (regfile_wdata),
        .pending       (pending),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of descriptors and arithmetic load formatting.
    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } mdesc_t;

    mdesc_t          mq[$];
    logic            m_we    = 1'b0;
    logic [4:0]      m_rd    = '0;
    logic [XLEN-1:0] m_wdata = '0;
    logic            m_err   = 1'b0;

    function automatic logic [31:0] model_fmt(input logic [2:0] f3, input int off, input logic [31:0] w);
        int size;
        bit sgn;
        longint unsigned mask;
        longint unsigned v;
        int start;
        case (f3)
            3'b000:  begin size = 1; sgn = 1'b1; end
            3'b100:  begin size = 1; sgn = 1'b0; end
            3'b001:  begin size = 2; sgn = 1'b1; end
            3'b101:  begin size = 2; sgn = 1'b0; end
            default: begin size = 4; sgn = 1'b1; end
        endcase
        start = off - (off % size);
        mask  = (64'd1 << (8 * size)) - 64'd1;
        v     = (longint'(w) >> (8 * start)) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic bit model_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        mdesc_t d;
        bit     do_push;
        if (rst) begin
            mq.delete();
            m_we    <= 1'b0;
            m_rd    <= '0;
            m_wdata <= '0;
            m_err   <= 1'b0;
        end else begin
            do_push = issue_valid && (mq.size() != DEPTH);
            m_we <= 1'b0;
            if (mem_resp) begin
                if (mq.size() == 0) begin
                    m_err <= 1'b1;
                end else begin
                    d = mq.pop_front();
                    if (d.rd != 0) begin
                        m_we    <= 1'b1;
                        m_rd    <= d.rd;
                        m_wdata <= model_fmt(d.f3, int'(d.off), mem_rdata);
                    end
                end
            end else if (alu_valid && alu_rd != 0) begin
                m_we    <= 1'b1;
                m_rd    <= alu_rd;
                m_wdata <= alu_data;
            end
            if (do_push) begin
                d.rd  = issue_rd;
                d.f3  = issue_funct3;
                d.off = issue_offset;
                mq.push_back(d);
                if (!model_legal(issue_funct3)) m_err <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cyc_we", load_regfile, m_we);
            if (m_we) begin
                check("cyc_rd", rd_reg, m_rd);
                check("cyc_wdata", regfile_wdata, m_wdata);
            end
            check("cyc_err", resp_err, m_err);
            check("cyc_pending", pending, mq.size());
            check("cyc_issue_ready", issue_ready, mq.size() != DEPTH);
            check("cyc_alu_ready", alu_ready, !mem_resp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_funct3 = f3;
        issue_offset = off;
        step();
        issue_valid  = 1'b0;
    endtask

    task automatic resp(input logic [31:0] data);
        mem_resp  = 1'b1;
        mem_rdata = data;
        step();
        mem_resp  = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
        step();
        alu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pending", pending, 0);
        check("rst_we", load_regfile, 0);
        check("rst_err", resp_err, 0);
        check("rst_issue_ready", issue_ready, 1);
        rst    = 1'b0;
        cmp_en = 1'b1;
        step();

        // lb x5, offset 3
        issue(5'd5, 3'b000, 2'd3);
        resp(32'h80FF_0000);
        check("lb_we", load_regfile, 1);
        check("lb_rd", rd_reg, 5);
        check("lb_wdata", regfile_wdata, 32'hFFFF_FF80);
        step();
        check("idle_we", load_regfile, 0);
        check("idle_hold_wdata", regfile_wdata, 32'hFFFF_FF80);

        // lhu x6 off 2, lh x7 off 0, back-to-back responses
        issue(5'd6, 3'b101, 2'd2);
        issue(5'd7, 3'b001, 2'd0);
        check("two_pending", pending, 2);
        mem_resp  = 1'b1;
        mem_rdata = 32'h8001_7FFE;
        step();
        check("lhu_rd", rd_reg, 6);
        check("lhu_wdata", regfile_wdata, 32'h0000_8001);
        step();
        mem_resp = 1'b0;
        check("lh_rd", rd_reg, 7);
        check("lh_wdata", regfile_wdata, 32'h0000_7FFE);
        check("drained", pending, 0);

        // Mixed load types including a load to x0
        issue(5'd8,  3'b100, 2'd1);
        issue(5'd9,  3'b001, 2'd3);
        issue(5'd10, 3'b000, 2'd0);
        issue(5'd0,  3'b010, 2'd0);
        resp(32'h0000_F200);
        check("lbu_wdata", regfile_wdata, 32'h0000_00F2);
        resp(32'h9ABC_0000);
        check("lh_off3_wdata", regfile_wdata, 32'hFFFF_9ABC);
        resp(32'h0000_007F);
        resp(32'h5555_5555);
        check("x0_load_we", load_regfile, 0);
        check("x0_load_pops", pending, 0);
        issue(5'd13, 3'b101, 2'd1);
        resp(32'h1234_8765);
        check("lhu_off1_wdata", regfile_wdata, 32'h0000_8765);

        // Simultaneous push and pop keeps pending unchanged
        issue(5'd15, 3'b000, 2'd2);
        issue_valid  = 1'b1;
        issue_rd     = 5'd16;
        issue_funct3 = 3'b100;
        issue_offset = 2'd3;
        mem_resp     = 1'b1;
        mem_rdata    = 32'h00AB_0000;
        step();
        issue_valid = 1'b0;
        mem_resp    = 1'b0;
        check("pushpop_pending", pending, 1);
        check("pushpop_wdata", regfile_wdata, 32'hFFFF_FFAB);
        resp(32'hC300_0000);
        check("lbu_off3_wdata", regfile_wdata, 32'h0000_00C3);

        // ALU writes, including x0
        alu(5'd14, 32'h0000_CAFE);
        check("alu_rd", rd_reg, 14);
        check("alu_wdata", regfile_wdata, 32'h0000_CAFE);
        alu(5'd0, 32'h0000_0001);
        check("alu_x0_we", load_regfile, 0);

        // Fill the FIFO, then push and respond in the same cycle
        for (int i = 1; i <= DEPTH; i++) issue(5'(i), 3'b010, 2'd0);
        check("full_pending", pending, DEPTH);
        check("full_ready", issue_ready, 0);
        issue_valid  = 1'b1;
        issue_rd     = 5'd20;
        issue_funct3 = 3'b010;
        mem_resp     = 1'b1;
        mem_rdata    = 32'h1111_1111;
        step();
        issue_valid = 1'b0;
        mem_resp    = 1'b0;
        check("full_pushpop_pending", pending, DEPTH - 1);
        check("full_resp_rd", rd_reg, 1);
        check("full_resp_wdata", regfile_wdata, 32'h1111_1111);
        resp(32'h2222_2222);
        resp(32'h3333_3333);
        resp(32'h4444_4444);
        check("full_last_rd", rd_reg, 4);
        check("full_drained", pending, 0);

        // ALU blocked by a concurrent load response
        issue(5'd10, 3'b010, 2'd0);
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h0000_1234;
        #1;
        check("alu_blocked", alu_ready, 0);
        step();
        mem_resp = 1'b0;
        check("prio_load_rd", rd_reg, 10);
        check("prio_load_wdata", regfile_wdata, 32'hDEAD_BEEF);
        #1;
        check("alu_unblocked", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("late_alu_rd", rd_reg, 9);
        check("late_alu_wdata", regfile_wdata, 32'h0000_1234);
        check("no_err_yet", resp_err, 0);

        // Unsupported funct3 sets the error flag and formats as lw
        issue(5'd12, 3'b011, 2'd2);
        check("illegal_err", resp_err, 1);
        resp(32'h8765_4321);
        check("illegal_rd", rd_reg, 12);
        check("illegal_wdata", regfile_wdata, 32'h8765_4321);
        issue(5'd17, 3'b111, 2'd1);
        resp(32'hF0F0_0F0F);

        // Reset clears the sticky error
        rst = 1'b1;
        #1;
        check("err_cleared", resp_err, 0);
        step();
        rst = 1'b0;

        // Response with nothing pending is dropped
        resp(32'hAAAA_AAAA);
        check("drop_we", load_regfile, 0);
        check("drop_err", resp_err, 1);

        // Asynchronous reset mid-burst
        alu_valid = 1'b1;
        alu_rd    = 5'd11;
        alu_data  = 32'h0000_0077;
        issue(5'd21, 3'b000, 2'd0);
        issue(5'd22, 3'b000, 2'd1);
        issue(5'd23, 3'b000, 2'd2);
        check("burst_pending", pending, 3);
        check("burst_we", load_regfile, 1);
        #2;
        rst = 1'b1;
        #1;
        alu_valid = 1'b0;
        check("async_pending", pending, 0);
        check("async_err", resp_err, 0);
        check("async_we", load_regfile, 0);
        check("async_rd", rd_reg, 0);
        check("async_wdata", regfile_wdata, 0);
        step();
        rst = 1'b0;

        check("post_rst_ready", issue_ready, 1);
        check("post_rst_alu_ready", alu_ready, 1);
        mem_resp  = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        #1;
        check("post_rst_alu_follow", alu_ready, 0);
        step();
        mem_resp = 1'b0;
        check("stale_resp_we", load_regfile, 0);
        check("stale_resp_err", resp_err, 1);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
